// File: rtl/i2s_clk_recv_if.sv
// -----------------------------------------------------------------------------
// i2s_clk_recv_if
// Serial-pin and sample bundle for the I2S clock generator / receiver.
//   data_in    : I2S serial data from the codec/ADC
//   sck        : mck/2 system clock out
//   bck        : mck/8 bit clock
//   lrck       : mck/512 word select (0 = left, 1 = right)
//   data_out   : last completely received sample
//   count      : bck slot index within the current channel (0..31)
//   data_valid : (I2S_STROBE_EN only) one-cycle pulse after data_out updates
//   data_ch    : (I2S_STROBE_EN only) channel of the captured word
// Modports: master = the receiver block, slave = the datapath/pin side.
// Optional feature macro: I2S_STROBE_EN.
// -----------------------------------------------------------------------------
interface i2s_clk_recv_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  data_in;
  logic                  sck;
  logic                  bck;
  logic                  lrck;
  logic [DATA_WIDTH-1:0] data_out;
  logic [4:0]            count;
`ifdef I2S_STROBE_EN
  logic                  data_valid;
  logic                  data_ch;

  modport master (
    input  data_in,
    output sck, bck, lrck, data_out, count, data_valid, data_ch
  );
  modport slave (
    output data_in,
    input  sck, bck, lrck, data_out, count, data_valid, data_ch
  );
`else
  modport master (
    input  data_in,
    output sck, bck, lrck, data_out, count
  );
  modport slave (
    output data_in,
    input  sck, bck, lrck, data_out, count
  );
`endif
endinterface

// File: rtl/i2s_clk_recv.sv
// -----------------------------------------------------------------------------
// i2s_clk_recv
// Single-clock I2S clock generator plus DATA_WIDTH-bit serial receiver.
// A 9-bit free-running counter on mck provides every output clock as a plain
// register bit: sck = cnt[0], bck = cnt[2], lrck = cnt[8], count = cnt[7:3].
// Serial data is sampled on the mck edge that raises bck (cnt[2:0] == 3'b011).
// Slot 0 is the I2S one-bit delay; slots 1..DATA_WIDTH carry MSB..LSB and the
// LSB sample edge loads data_out directly. Remaining slots are ignored.
// Ports:
//   mck   : master clock, all logic on its rising edge
//   reset : synchronous, active-low reset
//   bus   : i2s_clk_recv_if.master (data_in in; sck/bck/lrck/data_out/count out)
// Optional feature macro: I2S_STROBE_EN adds data_valid/data_ch to the bus.
// DATA_WIDTH must be <= 31 so that the LSB slot fits inside one channel.
// -----------------------------------------------------------------------------
module i2s_clk_recv #(
  parameter int DATA_WIDTH = 24
) (
  input  logic               mck,
  input  logic               reset,
  i2s_clk_recv_if.master     bus
);

  localparam logic [4:0] LAST_SLOT = 5'(DATA_WIDTH);

  logic [8:0]            cnt;
  logic [DATA_WIDTH-2:0] shift;   // MSB..LSB-1; the LSB comes straight from data_in
  logic [DATA_WIDTH-1:0] data_q;

  logic [4:0] slot;
  logic       sample;

  assign slot   = cnt[7:3];
  assign sample = (cnt[2:0] == 3'b011);   // same edge that drives bck 0->1

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge mck) begin
    if (!reset) begin
      cnt    <= '0;
      shift  <= '0;
      data_q <= '0;
    end else begin
      cnt <= cnt + 9'd1;
      if (sample) begin
        if (slot == 5'd0) begin
          shift <= '0;
        end else if (slot < LAST_SLOT) begin
          shift <= {shift[DATA_WIDTH-3:0], bus.data_in};
        end else if (slot == LAST_SLOT) begin
          data_q <= {shift, bus.data_in};
        end
      end
    end
  end

  assign bus.sck      = cnt[0];
  assign bus.bck      = cnt[2];
  assign bus.lrck     = cnt[8];
  assign bus.count    = slot;
  assign bus.data_out = data_q;

`ifdef I2S_STROBE_EN
  logic valid_q;
  logic ch_q;

  // The edge after the LSB capture sees cnt[2:0] == 3'b100 in the LSB slot,
  // so the pulse lands one cycle after data_out changes.
  always_ff @(posedge mck) begin
    if (!reset) begin
      valid_q <= 1'b0;
      ch_q    <= 1'b0;
    end else begin
      valid_q <= (cnt[7:0] == {LAST_SLOT, 3'b100});
      if (cnt[7:0] == {LAST_SLOT, 3'b100}) begin
        ch_q <= cnt[8];
      end
    end
  end

  assign bus.data_valid = valid_q;
  assign bus.data_ch    = ch_q;
`endif

endmodule

// File: tb/tb_i2s_clk_recv.sv
// -----------------------------------------------------------------------------
// tb_i2s_clk_recv
// Directed bench for i2s_clk_recv. A transmitter process shifts table words
// onto data_in, changing on bck falling edges. A behavioural model counts mck
// edges since reset release and derives every output arithmetically; data is
// reassembled from the bits observed at bck rising edges. A compare process
// checks the DUT on every falling mck edge, and the main sequence adds
// hand-computed literal expectations at fixed points.
// -----------------------------------------------------------------------------
module tb_i2s_clk_recv;

  localparam int DW = 24;

  logic mck;
  logic reset;

  i2s_clk_recv_if #(.DATA_WIDTH(DW)) bus ();

  i2s_clk_recv #(.DATA_WIDTH(DW)) dut (
    .mck   (mck),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    mck = 1'b0;
    forever #5 mck = ~mck;
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%h, want 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  // Two runs (before / after the mid-frame reset), 8 channels each,
  // even channel index = left.
  logic [23:0] words0 [8];
  logic        fill0  [8];
  logic [23:0] words1 [8];
  logic        fill1  [8];
  int          run;

  initial begin
    words0 = '{24'h888888, 24'h5A5A5A, 24'h1F3AF0, 24'hF0F0F0,
               24'h123456, 24'hABCDEF, 24'h000000, 24'h000000};
    fill0  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    words1 = '{24'h612345, 24'h3C3C3C, 24'hC0FFEE, 24'h000001,
               24'h000000, 24'h000000, 24'h000000, 24'h000000};
    fill1  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  end

  function automatic logic tx_bit(input int r, input int ch, input int slot);
    logic [23:0] w;
    logic        f;
    w = (r == 0) ? words0[ch % 8] : words1[ch % 8];
    f = (r == 0) ? fill0[ch % 8]  : fill1[ch % 8];
    if (slot >= 1 && slot <= DW) return w[DW - slot];
    return f;
  endfunction

  // ------------------------------------------------------------------- model
  int          n;          // mck edges since reset release
  logic [23:0] exp_data;
  logic        bitv [32];

  initial begin
    n        = 0;
    exp_data = '0;
  end

  always @(posedge mck) begin
    if (!reset) begin
      n        = 0;
      exp_data = '0;
    end else begin
      int p;
      p = n % 256;
      if (p % 8 == 3) begin
        bitv[p / 8] = bus.data_in;
        if (p / 8 == DW) begin
          logic [23:0] w;
          w = '0;
          for (int s = 1; s <= DW; s++) w[DW - s] = bitv[s];
          exp_data = w;
        end
      end
      n = n + 1;
    end
  end

  // Transmitter: slot index changes only when bck falls (n % 8 == 0).
  always @(posedge mck) begin
    #1;
    if (!reset) bus.data_in = 1'bx;
    else        bus.data_in = tx_bit(run, n / 256, (n % 256) / 8);
  end

  // ----------------------------------------------------------------- compare
  always @(negedge mck) begin
    logic [7:0] e_div;
    e_div = {((n % 2) == 1), (((n / 4) % 2) == 1), (((n / 256) % 2) == 1),
             5'((n / 8) % 32)};
    check("clkdiv", {24'd0, bus.sck, bus.bck, bus.lrck, bus.count}, {24'd0, e_div});
    check("data_out", {8'd0, bus.data_out}, {8'd0, exp_data});
`ifdef I2S_STROBE_EN
    check("data_valid", {31'd0, bus.data_valid}, {31'd0, 1'((n % 256) == DW * 8 + 5)});
    if ((n % 256) == DW * 8 + 5)
      check("data_ch", {31'd0, bus.data_ch}, {31'd0, 1'((n / 256) % 2)});
`endif
  end

  // -------------------------------------------------------------- main flow
  task automatic wait_n(input int target);
    int guard;
    guard = 0;
    while (n != target && guard < 5000) begin
      @(negedge mck);
      guard++;
    end
    if (n != target) check("wait_timeout", n, target);
  endtask

  initial begin
    reset       = 1'b0;
    run         = 0;
    bus.data_in = 1'bx;
    repeat (2) @(posedge mck);
    @(negedge mck);
    check("reset_state", {bus.sck, bus.bck, bus.lrck, bus.count, bus.data_out}, 32'd0);
    reset = 1'b1;

    wait_n(3);   check("bck_low_n3", {31'd0, bus.bck}, 32'd0);
    wait_n(4);   check("bck_high_n4", {31'd0, bus.bck}, 32'd1);
    wait_n(195); check("pre_lsb_left", {8'd0, bus.data_out}, 32'h000000);
    wait_n(196); check("lsb_left", {8'd0, bus.data_out}, 32'h888888);
    wait_n(255); check("lrck_low_255", {31'd0, bus.lrck}, 32'd0);
    wait_n(256); check("lrck_rise_256", {31'd0, bus.lrck}, 32'd1);
    wait_n(2 * 256 + 250);
    check("left_tail", {7'd0, bus.lrck, bus.data_out}, 32'h001F3AF0);
    wait_n(3 * 256 + 250);
    check("right_tail", {7'd0, bus.lrck, bus.data_out}, 32'h01F0F0F0);
    wait_n(4 * 256 + 250);
    check("ignored_slots", {8'd0, bus.data_out}, 32'h123456);

    // Reset in slot 12 of the next word.
    wait_n(5 * 256 + 12 * 8 + 2);
    reset = 1'b0;
    run   = 1;
    @(negedge mck);
    check("mid_reset_data", {8'd0, bus.data_out}, 32'd0);
    check("mid_reset_count", {27'd0, bus.count}, 32'd0);
    @(negedge mck);
    reset = 1'b1;

    wait_n(195); check("post_reset_pre", {8'd0, bus.data_out}, 32'h000000);
    wait_n(196); check("post_reset_word", {8'd0, bus.data_out}, 32'h612345);
    wait_n(600);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
